// File: rtl/awgn_stats_pkg.sv
// Shared types and width constants for the AWGN window statistics block.
// Optional max/min tracking is enabled by defining AWGN_STATS_MAXMIN_EN.
package awgn_stats_pkg;

    localparam int unsigned SAMPLE_W_DEF = 16;
    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned SUM_W        = SAMPLE_W_DEF + CNT_W_DEF;
    localparam int unsigned SUMSQ_W      = 2 * SAMPLE_W_DEF + CNT_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/awgn_stats_sq.sv
// Registered signed squarer: holds each accepted sample next to its exact square
// for one cycle so the accumulators see both together.
module awgn_stats_sq #(
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic signed [SAMPLE_W-1:0]     in_data,
    output logic                           out_valid,
    output logic signed [SAMPLE_W-1:0]     out_data,
    output logic        [2*SAMPLE_W-1:0]   out_sq
);

    localparam int unsigned PROD_W = 2 * SAMPLE_W;

    logic signed [PROD_W-1:0] prod_c;

    // Operands widened before the multiply so the full signed product is kept
    assign prod_c = PROD_W'(in_data) * PROD_W'(in_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sq    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_sq   <= $unsigned(prod_c);
            end
        end
    end

endmodule

// File: rtl/awgn_stats.sv
// Windowed sum / sum-of-squares of an AWGN sample stream with a result handshake.
// Define AWGN_STATS_MAXMIN_EN to add signed max/min outputs.
module awgn_stats
    import awgn_stats_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic        [CNT_W-1:0]             win_len,
    input  logic                                s_valid,
    input  logic signed [SAMPLE_W-1:0]          s_data,
    input  logic                                res_ready,
`ifdef AWGN_STATS_MAXMIN_EN
    output logic signed [SAMPLE_W-1:0]          res_max,
    output logic signed [SAMPLE_W-1:0]          res_min,
`endif
    output logic                                busy,
    output logic                                res_valid,
    output logic signed [SAMPLE_W+CNT_W-1:0]    res_sum,
    output logic        [2*SAMPLE_W+CNT_W-1:0]  res_sumsq
);

    localparam int unsigned ACC_W   = SAMPLE_W + CNT_W;
    localparam int unsigned ACCSQ_W = 2 * SAMPLE_W + CNT_W;

    state_t                       state;
    logic   [CNT_W-1:0]           len_q;
    logic   [CNT_W-1:0]           cnt;
    logic                         accept_c;
    logic                         start_c;
    logic                         sq_valid;
    logic signed [SAMPLE_W-1:0]   sq_data;
    logic        [2*SAMPLE_W-1:0] sq_sq;

    assign accept_c = (state == ST_ACCUM) && s_valid;
    assign start_c  = (state == ST_IDLE) && start;

    awgn_stats_sq #(
        .SAMPLE_W (SAMPLE_W)
    ) u_sq (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept_c),
        .in_data   (s_data),
        .out_valid (sq_valid),
        .out_data  (sq_data),
        .out_sq    (sq_sq)
    );

    // Control FSM; DRAIN covers the squarer latency so DONE sees the final add
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q <= win_len;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (s_valid) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == len_q) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AWGN_STATS_MAXMIN_EN
    logic first;
`endif

    // Accumulators double as the result registers; they only move while a window is open
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_sum   <= '0;
            res_sumsq <= '0;
`ifdef AWGN_STATS_MAXMIN_EN
            res_max   <= '0;
            res_min   <= '0;
            first     <= 1'b0;
`endif
        end else if (start_c) begin
            res_sum   <= '0;
            res_sumsq <= '0;
`ifdef AWGN_STATS_MAXMIN_EN
            res_max   <= '0;
            res_min   <= '0;
            first     <= 1'b1;
`endif
        end else if (sq_valid) begin
            res_sum   <= res_sum + ACC_W'(sq_data);
            res_sumsq <= res_sumsq + ACCSQ_W'(sq_sq);
`ifdef AWGN_STATS_MAXMIN_EN
            first <= 1'b0;
            if (first || (sq_data > res_max)) begin
                res_max <= sq_data;
            end
            if (first || (sq_data < res_min)) begin
                res_min <= sq_data;
            end
`endif
        end
    end

endmodule
